stack: RTL and testbench



---
 rtl/stack.sv | 58 +++++
 tb/tb_stack.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack.sv
// stack -- LIFO operand stack for the calculator datapath.
//
// Holds DEPTH entries of WIDTH bits; entry 0 is the top of stack. The two
// uppermost entries are exposed combinationally to the ALU. One command is
// applied per rising clock edge, with priority pop > push > write.
//
// Ports:
//   clock    in   1      system clock, all state changes on the rising edge
//   reset_n  in   1      asynchronous active-low reset, clears every entry
//   push     in   1      push: shift entries down, top is duplicated
//   pop      in   1      pop: shift entries up, bottom fills with zero
//   write    in   1      overwrite the top entry with value
//   value    in   WIDTH  data loaded into the top entry on write
//   top      out  WIDTH  entry 0
//   next     out  WIDTH  entry 1
module stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             write,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] e [DEPTH];

  // Only the highest-priority command executes. Empty slots are simply zero
  // words, so a pop on an empty stack just shifts zeros and a push past the
  // bottom silently discards the last entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        e[i] <= '0;
      end
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        e[i] <= e[i+1];
      end
      e[DEPTH-1] <= '0;
    end else if (push) begin
      // e[0] is left alone so the top value is duplicated into e[1]
      for (int i = 1; i < DEPTH; i++) begin
        e[i] <= e[i-1];
      end
    end else if (write) begin
      e[0] <= value;
    end
  end

  assign top  = e[0];
  assign next = e[1];

endmodule

// File: tb/tb_stack.sv
// tb_stack -- self-checking bench for the stack operand stack.
//
// A behavioural LIFO model (a SystemVerilog queue) predicts the top/next pair
// whenever a command is driven; the prediction goes into a scoreboard queue
// and is compared after the rising edge. Directed constant checks from the
// operating description are layered on top of the model checks.
module tb_stack;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clock;
  logic             reset_n;
  logic             push;
  logic             pop;
  logic             write;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;

  int checks;
  int errors;

  typedef struct {
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] n;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model[$];

  stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .write   (write),
    .value   (value),
    .top     (top),
    .next    (next)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model reset: every slot back to zero.
  task automatic modelClear();
    model.delete();
    for (int i = 0; i < DEPTH; i++) model.push_back('0);
  endtask

  // Model one edge with pop > push > write priority.
  task automatic modelStep(input logic p, input logic q, input logic w,
                           input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] dropped;
    if (q) begin
      dropped = model.pop_front();
      model.push_back('0);
    end else if (p) begin
      model.push_front(model[0]);
      dropped = model.pop_back();
    end else if (w) begin
      model[0] = v;
    end
  endtask

  // Compare the DUT against the oldest scoreboard entry.
  task automatic checkOutput();
    exp_t x;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard empty: got none expected one entry");
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      assert (top === x.t) else begin
        errors++;
        $error("[TB] FAIL %s top: got %h expected %h", x.tag, top, x.t);
      end
      checks++;
      assert (next === x.n) else begin
        errors++;
        $error("[TB] FAIL %s next: got %h expected %h", x.tag, next, x.n);
      end
    end
  endtask

  // Directed check against constants taken from the operating description.
  task automatic expectState(input string tag, input logic [WIDTH-1:0] t,
                             input logic [WIDTH-1:0] n);
    checks++;
    assert (top === t) else begin
      errors++;
      $error("[TB] FAIL %s const top: got %h expected %h", tag, top, t);
    end
    checks++;
    assert (next === n) else begin
      errors++;
      $error("[TB] FAIL %s const next: got %h expected %h", tag, next, n);
    end
  endtask

  // Drive one command between edges, predict, clock it, then compare.
  task automatic applyStimulus(input string tag, input logic p, input logic q,
                               input logic w, input logic [WIDTH-1:0] v);
    exp_t x;
    @(negedge clock);
    push  = p;
    pop   = q;
    write = w;
    value = v;
    modelStep(p, q, w, v);
    x.t   = model[0];
    x.n   = model[1];
    x.tag = tag;
    sb.push_back(x);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    @(negedge clock);
    push  = 1'b0;
    pop   = 1'b0;
    write = 1'b0;
    value = '0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    push    = 1'b0;
    pop     = 1'b0;
    write   = 1'b0;
    value   = '0;
    reset_n = 1'b0;
    modelClear();

    #1;
    expectState("reset", 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Write chain
    applyStimulus("write1", 1'b0, 1'b0, 1'b1, 32'd1);
    expectState("write1", 32'd1, 32'd0);
    applyStimulus("write2", 1'b0, 1'b0, 1'b1, 32'd2);
    expectState("write2", 32'd2, 32'd0);

    // Push/write sequence
    applyStimulus("push_a", 1'b1, 1'b0, 1'b0, 32'd0);
    expectState("push_a", 32'd2, 32'd2);
    applyStimulus("write3", 1'b0, 1'b0, 1'b1, 32'd3);
    expectState("write3", 32'd3, 32'd2);
    applyStimulus("push_b", 1'b1, 1'b0, 1'b0, 32'd0);
    expectState("push_b", 32'd3, 32'd3);
    applyStimulus("write4", 1'b0, 1'b0, 1'b1, 32'd4);
    expectState("write4", 32'd4, 32'd3);

    // Pop down to underflow; commands stay high across consecutive edges
    applyStimulus("pop1", 1'b0, 1'b1, 1'b0, 32'd0);
    expectState("pop1", 32'd3, 32'd2);
    applyStimulus("pop2", 1'b0, 1'b1, 1'b0, 32'd0);
    expectState("pop2", 32'd2, 32'd0);
    applyStimulus("pop3", 1'b0, 1'b1, 1'b0, 32'd0);
    expectState("pop3", 32'd0, 32'd0);
    applyStimulus("pop_under", 1'b0, 1'b1, 1'b0, 32'd0);
    expectState("pop_under", 32'd0, 32'd0);

    // Idle cycles hold state
    idle();
    applyStimulus("hold", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    expectState("hold", 32'd0, 32'd0);

    // Priority
    applyStimulus("prio_w7", 1'b0, 1'b0, 1'b1, 32'd7);
    applyStimulus("prio_push", 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus("prio_w5", 1'b0, 1'b0, 1'b1, 32'd5);
    expectState("prio_setup", 32'd5, 32'd7);
    applyStimulus("prio_all", 1'b1, 1'b1, 1'b1, 32'd9);
    expectState("prio_all", 32'd7, 32'd0);
    applyStimulus("prio_pw", 1'b1, 1'b0, 1'b1, 32'd9);
    expectState("prio_pw", 32'd7, 32'd7);

    // Empty the stack before the overflow run
    for (int i = 0; i < 3; i++) applyStimulus("clear", 1'b0, 1'b1, 1'b0, 32'd0);
    expectState("clear", 32'd0, 32'd0);

    // Overflow: fill 1..8, push once more, bottom value 1 is discarded
    applyStimulus("fill_w", 1'b0, 1'b0, 1'b1, 32'd1);
    for (int k = 2; k <= DEPTH; k++) begin
      applyStimulus("fill_p", 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus("fill_w", 1'b0, 1'b0, 1'b1, k);
    end
    expectState("full", 32'd8, 32'd7);
    applyStimulus("overflow", 1'b1, 1'b0, 1'b0, 32'd0);
    expectState("overflow", 32'd8, 32'd8);
    for (int k = 0; k < DEPTH; k++) begin
      logic [WIDTH-1:0] want;
      want = (k < DEPTH - 1) ? WIDTH'(DEPTH - k) : '0;
      applyStimulus("drain", 1'b0, 1'b1, 1'b0, 32'd0);
      checks++;
      assert (top === want) else begin
        errors++;
        $error("[TB] FAIL drain%0d top: got %h expected %h", k, top, want);
      end
    end

    // Async reset between edges with nonzero contents
    applyStimulus("pre_rst_w", 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    applyStimulus("pre_rst_p", 1'b1, 1'b0, 1'b0, 32'd0);
    expectState("pre_rst", 32'h1234_5678, 32'h1234_5678);
    @(negedge clock);
    push = 1'b1;
    #2;
    reset_n = 1'b0;
    modelClear();
    #1;
    expectState("async_rst", 32'h0, 32'h0);
    @(posedge clock);
    #1;
    expectState("rst_hold_push", 32'h0, 32'h0);
    @(negedge clock);
    push    = 1'b0;
    reset_n = 1'b1;
    applyStimulus("post_rst", 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    expectState("post_rst", 32'hDEAD_BEEF, 32'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
